// File: rtl/transmit_delay_scheduler_pkg.sv
// Shared types and default widths for the transmit delay scheduler.
// Optional feature macro: TX_DELAY_SCHED_MASK_EN (per-element fire mask).
package tx_sched_pkg;

   localparam int NUM_ELEMENTS_DEF = 64;
   localparam int DW_N_INTEGER_DEF = 13;
   localparam int DW_FRACTION_DEF  = 4;

   // Rounded integer delay carries one extra bit for the round-up carry.
   localparam int DW_DELAY_DEF = DW_N_INTEGER_DEF + 1;
   localparam int DW_TIMER_DEF = DW_N_INTEGER_DEF + 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FIRING,
      ST_DONE
   } state_e;

   typedef logic [DW_DELAY_DEF-1:0] delay_t;

   function automatic int delay_max(input int dw_int);
      return (1 << (dw_int + 1)) - 1;
   endfunction

endpackage

// File: rtl/transmit_delay_scheduler_if.sv
// Handshake bundle between the delay array, the trigger source and the scheduler.
// Optional feature macro: TX_DELAY_SCHED_MASK_EN adds element_mask.
interface transmit_delay_scheduler_if #(
   parameter int NUM_ELEMENTS = 64,
   parameter int DW_N         = 18
);

   logic [NUM_ELEMENTS-1:0][DW_N-1:0] n_in;
   logic                              n_valid;
   logic                              ack;
   logic                              start;
   logic [NUM_ELEMENTS-1:0]           fire;
   logic                              transmit_done;
   logic                              busy;
   logic                              underrun;
`ifdef TX_DELAY_SCHED_MASK_EN
   logic [NUM_ELEMENTS-1:0]           element_mask;

   modport master (
      output n_in, n_valid, start, element_mask,
      input  ack, fire, transmit_done, busy, underrun
   );

   modport slave (
      input  n_in, n_valid, start, element_mask,
      output ack, fire, transmit_done, busy, underrun
   );
`else
   modport master (
      output n_in, n_valid, start,
      input  ack, fire, transmit_done, busy, underrun
   );

   modport slave (
      input  n_in, n_valid, start,
      output ack, fire, transmit_done, busy, underrun
   );
`endif

endinterface

// File: rtl/transmit_delay_scheduler_delay_round_sat.sv
// Rounds one fixed-point delay to whole clock ticks (half rounds up) and
// saturates the result to the integer delay range.
module delay_round_sat #(
   parameter int DW_N_INTEGER = 13,
   parameter int DW_FRACTION  = 4
) (
   input  logic [DW_N_INTEGER+DW_FRACTION:0] n_i,
   output logic [DW_N_INTEGER:0]             d_o
);

   localparam int DW_D = DW_N_INTEGER + 1;

   logic [DW_D:0] sum;

   assign sum = {1'b0, n_i[DW_N_INTEGER+DW_FRACTION:DW_FRACTION]}
              + {{DW_D{1'b0}}, n_i[DW_FRACTION-1]};

   assign d_o = sum[DW_D] ? {DW_D{1'b1}} : sum[DW_D-1:0];

endmodule

// File: rtl/transmit_delay_scheduler.sv
// Double-buffered delay scheduler: captures rounded delays, fires one pulse per
// element at its tick on start. Optional macro: TX_DELAY_SCHED_MASK_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for start; start without shadow data -> underrun
// ST_FIRING | timer running, elements pulse fire when timer hits delay
// ST_DONE   | one cycle issuing transmit_done, then back to idle
module transmit_delay_scheduler
   import tx_sched_pkg::*;
#(
   parameter int NUM_ELEMENTS = NUM_ELEMENTS_DEF,
   parameter int DW_N_INTEGER = DW_N_INTEGER_DEF,
   parameter int DW_FRACTION  = DW_FRACTION_DEF
) (
   input logic                        clk,
   input logic                        rst,
   transmit_delay_scheduler_if.slave  bus
);

   localparam int DW_D = DW_N_INTEGER + 1;
   localparam int DW_T = DW_N_INTEGER + 2;

   logic [NUM_ELEMENTS-1:0][DW_D-1:0] d_round;
   logic [NUM_ELEMENTS-1:0][DW_D-1:0] shadow_q;
   logic [NUM_ELEMENTS-1:0][DW_D-1:0] active_q;
   logic                              shadow_valid_q;
   state_e                            state_q;
   logic [DW_T-1:0]                   timer_q;
   logic [NUM_ELEMENTS-1:0]           fired_q;
   logic [NUM_ELEMENTS-1:0]           fired_d;
   logic [NUM_ELEMENTS-1:0]           fire_q;
   logic [NUM_ELEMENTS-1:0]           fire_d;
   logic [NUM_ELEMENTS-1:0]           mask_start;
   logic                              ack_q;
   logic                              done_q;
   logic                              busy_q;
   logic                              underrun_q;
   logic                              capture;
   logic                              accept;

   for (genvar g = 0; g < NUM_ELEMENTS; g++) begin : g_round
      delay_round_sat #(
         .DW_N_INTEGER (DW_N_INTEGER),
         .DW_FRACTION  (DW_FRACTION)
      ) u_round (
         .n_i (bus.n_in[g]),
         .d_o (d_round[g])
      );
   end

`ifdef TX_DELAY_SCHED_MASK_EN
   assign mask_start = bus.element_mask;
`else
   assign mask_start = '1;
`endif

   // Shadow can only be full when a copy is accepted, so copy wins naturally.
   assign capture = bus.n_valid && !shadow_valid_q;
   assign accept  = (state_q == ST_IDLE) && bus.start && shadow_valid_q;

   always_comb begin
      fire_d = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
         fire_d[i] = (timer_q == {1'b0, active_q[i]}) && !fired_q[i];
      end
      fired_d = fired_q | fire_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_valid_q <= 1'b0;
         shadow_q       <= '0;
         ack_q          <= 1'b0;
      end else begin
         ack_q <= capture;
         if (capture) begin
            shadow_q       <= d_round;
            shadow_valid_q <= 1'b1;
         end else if (accept) begin
            shadow_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         fired_q    <= '0;
         active_q   <= '0;
         fire_q     <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         fire_q     <= '0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         busy_q     <= (state_q == ST_FIRING);
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (shadow_valid_q) begin
                     active_q <= shadow_q;
                     fired_q  <= ~mask_start;
                     timer_q  <= '0;
                     state_q  <= ST_FIRING;
                  end else begin
                     underrun_q <= 1'b1;
                  end
               end
            end
            ST_FIRING: begin
               fire_q  <= fire_d;
               fired_q <= fired_d;
               timer_q <= timer_q + 1'b1;
               if (&fired_d) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.ack           = ack_q;
   assign bus.fire          = fire_q;
   assign bus.transmit_done = done_q;
   assign bus.busy          = busy_q;
   assign bus.underrun      = underrun_q;

endmodule

// File: tb/tb_transmit_delay_scheduler.sv
// Bench for transmit_delay_scheduler: absolute-time reference model compared
// every cycle, plus directed literal timing checks.
module tb_transmit_delay_scheduler;
   import tx_sched_pkg::*;

   localparam int NE   = 64;
   localparam int DWI  = 13;
   localparam int DWF  = 4;
   localparam int DWN  = DWI + DWF + 1;
   localparam int DSAT = (1 << (DWI + 1)) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   transmit_delay_scheduler_if #(.NUM_ELEMENTS(NE), .DW_N(DWN)) bus ();

   transmit_delay_scheduler #(
      .NUM_ELEMENTS (NE),
      .DW_N_INTEGER (DWI),
      .DW_FRACTION  (DWF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name, input int budget);
      checks++;
      errors++;
      $display("FAIL %s: no event within %0d cycles, expected one", name, budget);
   endtask

   // Reference: round half up, then clamp.
   function automatic int rnd(input int n);
      int r;
      r = (n + (1 << (DWF - 1))) >> DWF;
      return (r > DSAT) ? DSAT : r;
   endfunction

   // ---------------- reference model (absolute cycle arithmetic) ----------
   int            cyc = 0;
   bit            m_sv;
   int            m_sh[NE];
   bit            m_run;
   int            m_ts;
   int            m_act[NE];
   bit            m_en[NE];
   int            m_maxd;
   logic [NE-1:0] x_fire;
   logic          x_busy, x_done, x_ack, x_und;

   always @(posedge clk) begin
      bit idle, acc, cap;
      cyc++;
      if (rst) begin
         m_sv   = 1'b0;
         m_run  = 1'b0;
         x_fire = '0;
         x_busy = 1'b0;
         x_done = 1'b0;
         x_ack  = 1'b0;
         x_und  = 1'b0;
      end else begin
         idle = !m_run || (cyc >= m_ts + 3 + m_maxd);
         if (idle) m_run = 1'b0;
         acc   = idle && bus.start && m_sv;
         x_und = idle && bus.start && !m_sv;
         cap   = bus.n_valid && !m_sv;
         x_ack = cap;
         if (acc) begin
            m_run  = 1'b1;
            m_ts   = cyc;
            m_act  = m_sh;
            m_maxd = 0;
            for (int i = 0; i < NE; i++) begin
`ifdef TX_DELAY_SCHED_MASK_EN
               m_en[i] = bus.element_mask[i];
`else
               m_en[i] = 1'b1;
`endif
               if (m_en[i] && m_act[i] > m_maxd) m_maxd = m_act[i];
            end
            m_sv = 1'b0;
         end
         if (cap) begin
            for (int i = 0; i < NE; i++) m_sh[i] = rnd(int'(bus.n_in[i]));
            m_sv = 1'b1;
         end
         for (int i = 0; i < NE; i++)
            x_fire[i] = m_run && m_en[i] && (cyc == m_ts + 1 + m_act[i]);
         x_busy = m_run && (cyc >= m_ts + 1) && (cyc <= m_ts + 1 + m_maxd);
         x_done = m_run && (cyc == m_ts + 2 + m_maxd);
      end
      #1;
      check("fire", bus.fire, x_fire);
      check("busy", bus.busy, x_busy);
      check("transmit_done", bus.transmit_done, x_done);
      check("ack", bus.ack, x_ack);
      check("underrun", bus.underrun, x_und);
   end

   // ---------------- stimulus ---------------------------------------------
   int pat[NE];

   task automatic load(output int ack_k, output logic busy_at);
      @(negedge clk);
      for (int i = 0; i < NE; i++) bus.n_in[i] = pat[i][DWN-1:0];
      bus.n_valid = 1'b1;
      ack_k   = -1;
      busy_at = 1'b0;
      for (int j = 1; j <= 50; j++) begin
         @(posedge clk);
         #1;
         if (bus.ack) begin
            ack_k   = j;
            busy_at = bus.busy;
            break;
         end
      end
      if (ack_k < 0) timeout("ack_wait", 50);
      @(negedge clk);
      bus.n_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int k);
      k = -1;
      for (int j = 1; j <= budget; j++) begin
         @(posedge clk);
         #1;
         if (bus.transmit_done) begin
            k = j;
            break;
         end
      end
      if (k < 0) timeout("done_wait", budget);
   endtask

   initial begin
      int            ack_k, k, f0, f1, f2, f63, dk, ack_mid, nfire;
      logic          busy_at, busy_mid;
      logic [NE-1:0] acc_fire;
      rst         = 1'b1;
      bus.n_valid = 1'b0;
      bus.start   = 1'b0;
      bus.n_in    = '0;
`ifdef TX_DELAY_SCHED_MASK_EN
      bus.element_mask = '1;
`endif
      repeat (3) @(negedge clk);
      check("reset_fire", bus.fire, '0);
      check("reset_busy", bus.busy, 1'b0);
      rst = 1'b0;

      // start with empty shadow
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      check("underrun_pulse", bus.underrun, 1'b1);
      check("underrun_busy", bus.busy, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;

      // d_i = i
      for (int i = 0; i < NE; i++) pat[i] = 16 * i;
      load(ack_k, busy_at);
      check("ack_latency", ack_k, 1);
      pulse_start();
      f0 = -1; f63 = -1; dk = -1;
      for (int j = 1; j <= 80; j++) begin
         @(posedge clk);
         #1;
         if (bus.fire[0] && f0 < 0) f0 = j;
         if (bus.fire[63] && f63 < 0) f63 = j;
         if (bus.transmit_done && dk < 0) dk = j;
      end
      check("fire0_tick", f0, 1);
      check("fire63_tick", f63, 64);
      check("done_tick", dk, 65);

      // rounding, saturation and capture during firing
      for (int i = 0; i < NE; i++) pat[i] = $urandom_range(0, 400);
      pat[0] = 'h18;
      pat[1] = 'h17;
      pat[2] = (1 << DWN) - 1;
      load(ack_k, busy_at);
      for (int i = 0; i < NE; i++) pat[i] = $urandom_range(0, 480);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.n_valid = 1'b1;
      for (int i = 0; i < NE; i++) bus.n_in[i] = pat[i][DWN-1:0];
      @(negedge clk);
      bus.start = 1'b0;
      f0 = -1; f1 = -1; f2 = -1; dk = -1; ack_mid = -1; busy_mid = 1'b0;
      for (int j = 1; j <= 17000; j++) begin
         @(posedge clk);
         #1;
         if (bus.ack && ack_mid < 0) begin
            ack_mid     = j;
            busy_mid    = bus.busy;
            bus.n_valid = 1'b0;
         end
         if (bus.fire[0] && f0 < 0) f0 = j;
         if (bus.fire[1] && f1 < 0) f1 = j;
         if (bus.fire[2] && f2 < 0) f2 = j;
         if (bus.transmit_done) begin
            dk = j;
            break;
         end
      end
      check("ack_after_copy", ack_mid, 1);
      check("ack_while_busy", busy_mid, 1'b1);
      check("round_up_half", f0, 3);
      check("round_down", f1, 2);
      check("saturated_fire", f2, DSAT + 1);
      check("saturated_done", dk, DSAT + 2);

      // start in the first idle cycle after transmit_done
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      check("b2b_no_underrun", bus.underrun, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(600, k);

      // reset at timer=10
      for (int i = 0; i < NE; i++) pat[i] = 16 * i;
      load(ack_k, busy_at);
      pulse_start();
      acc_fire = '0;
      for (int j = 1; j <= 10; j++) begin
         @(posedge clk);
         #1;
         acc_fire |= bus.fire;
      end
      check("pre_reset_fired", acc_fire, 64'h3FF);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("reset_abort_fire", bus.fire, '0);
      check("reset_abort_busy", bus.busy, 1'b0);
      @(negedge clk);
      rst      = 1'b0;
      acc_fire = '0;
      dk       = 0;
      for (int j = 0; j < 80; j++) begin
         @(posedge clk);
         #1;
         acc_fire |= bus.fire;
         if (bus.transmit_done) dk++;
      end
      check("post_reset_fire", acc_fire, '0);
      check("post_reset_done", dk, 0);

      // randomized transmissions
      for (int it = 0; it < 8; it++) begin
         if ($urandom_range(0, 2) == 0) pulse_start();
         for (int i = 0; i < NE; i++) pat[i] = $urandom_range(0, 40 * 16 + 15);
         pat[$urandom_range(0, NE - 1)] = 40 * 16;
         load(ack_k, busy_at);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         pulse_start();
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 8)) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
         end
         wait_done(200, k);
      end

`ifdef TX_DELAY_SCHED_MASK_EN
      for (int i = 0; i < NE; i++) pat[i] = 16 * i;
      load(ack_k, busy_at);
      bus.element_mask = 64'h0F0F;
      pulse_start();
      bus.element_mask = '1;
      nfire = 0;
      dk    = -1;
      for (int j = 1; j <= 80; j++) begin
         @(posedge clk);
         #1;
         nfire += $countones(bus.fire);
         if (bus.transmit_done && dk < 0) dk = j;
      end
      check("mask_fire_count", nfire, 8);
      check("mask_done_tick", dk, 13);

      load(ack_k, busy_at);
      bus.element_mask = '0;
      pulse_start();
      bus.element_mask = '1;
      nfire = 0;
      dk    = -1;
      for (int j = 1; j <= 10; j++) begin
         @(posedge clk);
         #1;
         nfire += $countones(bus.fire);
         if (bus.transmit_done && dk < 0) dk = j;
      end
      check("zero_mask_fire_count", nfire, 0);
      check("zero_mask_done_tick", dk, 2);
`endif

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
